// File: rtl/ysyx_axi4_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_axi4_sram_slave
// Purpose  : AXI4 responder backed by a 64-bit-wide memory array. Handles one
//            read or write transaction at a time, with FIXED/INCR bursts, byte
//            strobes and a configurable read latency.
// Option   : YSYX_AXI_SLV_DECERR_EN - out-of-range beats return DECERR
//            (read data zeroed, writes discarded).
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_axi4_sram_slave #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DEPTH_LOG2 = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned       R_LAT      = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  // read address channel
  input  logic [1:0]        arburst,
  input  logic [2:0]        arsize,
  input  logic [7:0]        arlen,
  input  logic [3:0]        arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  // read data channel
  output logic [3:0]        rid,
  output logic [63:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  // write address channel
  input  logic [1:0]        awburst,
  input  logic [2:0]        awsize,
  input  logic [7:0]        awlen,
  input  logic [3:0]        awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  // write data channel
  input  logic [63:0]       wdata,
  input  logic [7:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  // write response channel
  output logic [3:0]        bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  localparam int unsigned WORDS = 1 << DEPTH_LOG2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    R_WAIT = 3'd1,
    R_DATA = 3'd2,
    W_DATA = 3'd3,
    W_RESP = 3'd4
  } state_t;

  state_t r_state, w_state_nxt;

  logic [63:0]           r_mem [WORDS];
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [DEPTH_LOG2-1:0] w_idx_step;
  logic [1:0]            r_burst;
  logic [7:0]            r_len;
  logic [7:0]            r_beat;
  logic [3:0]            r_lat;
  logic                  w_aw_hs;
  logic                  w_ar_hs;
  logic                  w_last_wbeat;
  logic                  w_mem_we;
  logic                  w_unused;

`ifdef YSYX_AXI_SLV_DECERR_EN
  logic [ADDR_W-1:0]     r_addr;
  logic [ADDR_W-1:0]     w_addr_step;
  logic                  r_werr;
  logic                  w_beat_ok;
  logic                  w_step_ok;
`endif

  // Transfer size is implied by the 64-bit data path; the size fields carry
  // no information this responder needs.
  assign w_unused = ^{arsize, awsize};

  // Word index of a byte address, relative to the decoded base.
  function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return DEPTH_LOG2'((a - BASE_ADDR) >> 3);
  endfunction

`ifdef YSYX_AXI_SLV_DECERR_EN
  // True when the byte address falls inside the backing memory window.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ((a - BASE_ADDR) >> (DEPTH_LOG2 + 3)) == '0;
  endfunction
`endif

  // Handshake outputs derive from the state; all are forced low while in reset.
  assign awready = rst_n && (r_state == IDLE);
  assign arready = rst_n && (r_state == IDLE) && !awvalid;
  assign wready  = rst_n && (r_state == W_DATA);
  assign rvalid  = rst_n && (r_state == R_DATA);
  assign bvalid  = rst_n && (r_state == W_RESP);

  assign w_aw_hs = awvalid && awready;
  assign w_ar_hs = arvalid && arready;

  // FIXED keeps the index; INCR, WRAP and reserved all step by one word.
  assign w_idx_step   = (r_burst == 2'b00) ? r_idx : r_idx + DEPTH_LOG2'(1);
  // A write burst ends on the final counted beat or on an early wlast.
  assign w_last_wbeat = (r_beat == r_len) || wlast;

`ifdef YSYX_AXI_SLV_DECERR_EN
  assign w_addr_step = (r_burst == 2'b00) ? r_addr : r_addr + ADDR_W'(8);
  assign w_beat_ok   = in_range(r_addr);
  assign w_step_ok   = in_range(w_addr_step);
  assign w_mem_we    = wready && wvalid && w_beat_ok;
`else
  assign w_mem_we    = wready && wvalid;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a write wins over a simultaneous read request.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_aw_hs) begin
          w_state_nxt = W_DATA;
        end else if (w_ar_hs) begin
          w_state_nxt = R_WAIT;
        end
      end
      R_WAIT: begin
        if (r_lat == 4'd0) begin
          w_state_nxt = R_DATA;
        end
      end
      R_DATA: begin
        if (rready && rlast) begin
          w_state_nxt = IDLE;
        end
      end
      W_DATA: begin
        if (wvalid && w_last_wbeat) begin
          w_state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (bready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Transaction context, beat tracking and registered response fields.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_burst <= 2'b00;
      r_len   <= 8'd0;
      r_beat  <= 8'd0;
      r_lat   <= 4'd0;
      rdata   <= 64'd0;
      rresp   <= 2'b00;
      rlast   <= 1'b0;
      rid     <= 4'd0;
      bid     <= 4'd0;
      bresp   <= 2'b00;
`ifdef YSYX_AXI_SLV_DECERR_EN
      r_addr  <= '0;
      r_werr  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_aw_hs) begin
            r_idx   <= word_idx(awaddr);
            r_burst <= awburst;
            r_len   <= awlen;
            r_beat  <= 8'd0;
            bid     <= awid;
`ifdef YSYX_AXI_SLV_DECERR_EN
            r_addr  <= awaddr;
            r_werr  <= 1'b0;
`endif
          end else if (w_ar_hs) begin
            r_idx   <= word_idx(araddr);
            r_burst <= arburst;
            r_len   <= arlen;
            r_beat  <= 8'd0;
            r_lat   <= 4'(R_LAT - 1);
            rid     <= arid;
`ifdef YSYX_AXI_SLV_DECERR_EN
            r_addr  <= araddr;
`endif
          end
        end
        R_WAIT: begin
          if (r_lat == 4'd0) begin
            rlast <= (r_len == 8'd0);
`ifdef YSYX_AXI_SLV_DECERR_EN
            rdata <= w_beat_ok ? r_mem[r_idx] : 64'd0;
            rresp <= w_beat_ok ? 2'b00 : 2'b11;
`else
            rdata <= r_mem[r_idx];
            rresp <= 2'b00;
`endif
          end else begin
            r_lat <= r_lat - 4'd1;
          end
        end
        R_DATA: begin
          // Response fields only move on a handshake, so they hold under stall.
          if (rready) begin
            if (rlast) begin
              rlast <= 1'b0;
            end else begin
              r_idx  <= w_idx_step;
              r_beat <= r_beat + 8'd1;
              rlast  <= ((r_beat + 8'd1) == r_len);
`ifdef YSYX_AXI_SLV_DECERR_EN
              r_addr <= w_addr_step;
              rdata  <= w_step_ok ? r_mem[w_idx_step] : 64'd0;
              rresp  <= w_step_ok ? 2'b00 : 2'b11;
`else
              rdata  <= r_mem[w_idx_step];
`endif
            end
          end
        end
        W_DATA: begin
          if (wvalid) begin
`ifdef YSYX_AXI_SLV_DECERR_EN
            if (!w_beat_ok) begin
              r_werr <= 1'b1;
            end
`endif
            if (w_last_wbeat) begin
`ifdef YSYX_AXI_SLV_DECERR_EN
              bresp <= (r_werr || !w_beat_ok) ? 2'b11 : 2'b00;
`else
              bresp <= 2'b00;
`endif
            end else begin
              r_idx  <= w_idx_step;
              r_beat <= r_beat + 8'd1;
`ifdef YSYX_AXI_SLV_DECERR_EN
              r_addr <= w_addr_step;
`endif
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Byte-lane write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 8; i++) begin
        if (wstrb[i]) begin
          r_mem[r_idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_axi4_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_axi4_sram_slave
// Purpose  : Directed self-checking bench for ysyx_axi4_sram_slave.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ysyx_axi4_sram_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  arburst, awburst;
  logic [2:0]  arsize, awsize;
  logic [7:0]  arlen, awlen;
  logic [3:0]  arid, awid;
  logic [31:0] araddr, awaddr;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic        awvalid, awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  int checks   = 0;
  int failures = 0;
  int lat;

  logic [63:0] rd_data [16];
  logic        rd_last [16];
  logic [1:0]  rd_resp [16];
  logic [3:0]  rd_id   [16];

  always #5 clk = ~clk;

  ysyx_axi4_sram_slave dut (
    .clk(clk), .rst_n(rst_n),
    .arburst(arburst), .arsize(arsize), .arlen(arlen), .arid(arid),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awburst(awburst), .awsize(awsize), .awlen(awlen), .awid(awid),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 ns later.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_aw(input logic [31:0] a, input logic [7:0] len,
                       input logic [1:0] burst, input logic [3:0] id);
    int n;
    awaddr = a; awlen = len; awburst = burst; awid = id; awsize = 3'd3;
    awvalid = 1'b1;
    #1;
    n = 0;
    while (!awready && n < 40) begin tick; n++; end
    check("aw_wait", 64'(n < 40), 64'd1);
    tick;
    awvalid = 1'b0;
  endtask

  task automatic do_w(input logic [63:0] d0, input logic [7:0] strb, input int nb);
    int n;
    for (int k = 0; k < nb; k++) begin
      wdata = d0 + 64'(k); wstrb = strb; wlast = (k == nb - 1); wvalid = 1'b1;
      n = 0;
      while (!wready && n < 40) begin tick; n++; end
      check("w_wait", 64'(n < 40), 64'd1);
      tick;
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic do_b(input logic [3:0] id, input logic [1:0] resp);
    check("bvalid", 64'(bvalid), 64'd1);
    check("bresp", 64'(bresp), 64'(resp));
    check("bid", 64'(bid), 64'(id));
    bready = 1'b1;
    tick;
    bready = 1'b0;
    check("bvalid_clear", 64'(bvalid), 64'd0);
  endtask

  // Issue AR and count cycles from the handshake edge to rvalid.
  task automatic do_ar(input logic [31:0] a, input logic [7:0] len,
                       input logic [1:0] burst, input logic [3:0] id, output int l);
    int n;
    araddr = a; arlen = len; arburst = burst; arid = id; arsize = 3'd3;
    arvalid = 1'b1;
    #1;
    n = 0;
    while (!arready && n < 40) begin tick; n++; end
    check("ar_wait", 64'(n < 40), 64'd1);
    tick;
    arvalid = 1'b0;
    l = 0;
    while (!rvalid && l < 40) begin tick; l++; end
  endtask

  task automatic read_beats(input int nb);
    rready = 1'b1;
    for (int k = 0; k < nb; k++) begin
      check("rvalid_beat", 64'(rvalid), 64'd1);
      rd_data[k] = rdata; rd_last[k] = rlast; rd_resp[k] = rresp; rd_id[k] = rid;
      tick;
    end
    rready = 1'b0;
    check("rvalid_end", 64'(rvalid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    arburst = 2'b01; awburst = 2'b01; arsize = 3'd3; awsize = 3'd3;
    arlen = 8'd0; awlen = 8'd0; arid = 4'd0; awid = 4'd0;
    araddr = 32'h8000_0000; awaddr = 32'h0; arvalid = 1'b1; awvalid = 1'b0;
    rready = 1'b0; wdata = 64'd0; wstrb = 8'd0; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b0;

    // Reset held for three edges with a pending read request.
    repeat (3) begin
      tick;
      check("rst_arready", 64'(arready), 64'd0);
      check("rst_rvalid", 64'(rvalid), 64'd0);
      check("rst_bvalid", 64'(bvalid), 64'd0);
    end
    rst_n = 1'b1;
    #1;
    check("post_rst_arready", 64'(arready), 64'd1);
    arvalid = 1'b0;

    // Single partial-strobe write, then read back.
    do_aw(32'h8000_0008, 8'd0, 2'b01, 4'h3);
    do_w(64'h1122_3344_5566_7788, 8'h0F, 1);
    do_b(4'h3, 2'b00);
    do_ar(32'h8000_0008, 8'd0, 2'b01, 4'h5, lat);
    check("rd_latency", 64'(lat), 64'd2);
    read_beats(1);
    check("single_data_lo", 64'(rd_data[0][31:0]), 64'h5566_7788);
    check("single_rlast", 64'(rd_last[0]), 64'd1);
    check("single_rid", 64'(rd_id[0]), 64'h5);
    check("single_rresp", 64'(rd_resp[0]), 64'd0);

    // Four-beat INCR write and read.
    do_aw(32'h8000_0100, 8'd3, 2'b01, 4'h1);
    do_w(64'd0, 8'hFF, 4);
    do_b(4'h1, 2'b00);
    do_ar(32'h8000_0100, 8'd3, 2'b01, 4'h2, lat);
    read_beats(4);
    for (int k = 0; k < 4; k++) begin
      check("incr_data", rd_data[k], 64'(k));
      check("incr_rlast", 64'(rd_last[k]), 64'(k == 3));
      check("incr_rid", 64'(rd_id[k]), 64'h2);
    end

    // Back-pressure: hold beat 0 for five cycles.
    do_ar(32'h8000_0100, 8'd1, 2'b01, 4'h6, lat);
    for (int i = 0; i < 5; i++) begin
      check("bp_rvalid", 64'(rvalid), 64'd1);
      check("bp_rdata", rdata, 64'd0);
      check("bp_rlast", 64'(rlast), 64'd0);
      tick;
    end
    rready = 1'b1;
    tick;
    check("bp_beat1_valid", 64'(rvalid), 64'd1);
    check("bp_beat1_data", rdata, 64'd1);
    check("bp_beat1_last", 64'(rlast), 64'd1);
    check("bp_beat1_rid", 64'(rid), 64'h6);
    tick;
    rready = 1'b0;
    check("bp_done", 64'(rvalid), 64'd0);

    // Zero strobe leaves the word untouched.
    do_aw(32'h8000_0108, 8'd0, 2'b01, 4'h0);
    do_w(64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1);
    do_b(4'h0, 2'b00);
    do_ar(32'h8000_0108, 8'd0, 2'b01, 4'h0, lat);
    read_beats(1);
    check("strb0_data", rd_data[0], 64'd1);

    // FIXED burst: both beats land on one word, last one wins.
    do_aw(32'h8000_0300, 8'd1, 2'b00, 4'h7);
    do_w(64'hA0, 8'hFF, 2);
    do_b(4'h7, 2'b00);
    do_ar(32'h8000_0300, 8'd1, 2'b00, 4'h7, lat);
    read_beats(2);
    check("fixed_b0", rd_data[0], 64'hA1);
    check("fixed_b1", rd_data[1], 64'hA1);
    check("fixed_last", 64'(rd_last[1]), 64'd1);

    // Early wlast on beat 2 of a 4-beat burst.
    do_aw(32'h8000_0400, 8'd3, 2'b01, 4'h8);
    do_w(64'h50, 8'hFF, 2);
    do_b(4'h8, 2'b00);
    do_ar(32'h8000_0400, 8'd1, 2'b01, 4'h8, lat);
    read_beats(2);
    check("early_b0", rd_data[0], 64'h50);
    check("early_b1", rd_data[1], 64'h51);

    // Contention: write wins, read follows the B handshake.
    awaddr = 32'h8000_0200; awlen = 8'd0; awburst = 2'b01; awid = 4'h9; awvalid = 1'b1;
    araddr = 32'h8000_0200; arlen = 8'd0; arburst = 2'b01; arid = 4'hA; arvalid = 1'b1;
    #1;
    check("cont_awready", 64'(awready), 64'd1);
    check("cont_arready", 64'(arready), 64'd0);
    tick;
    awvalid = 1'b0;
    #1;
    check("cont_arready_wdata", 64'(arready), 64'd0);
    do_w(64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 1);
    check("cont_arready_wresp", 64'(arready), 64'd0);
    do_b(4'h9, 2'b00);
    check("cont_arready_idle", 64'(arready), 64'd1);
    do_ar(32'h8000_0200, 8'd0, 2'b01, 4'hA, lat);
    read_beats(1);
    check("cont_data", rd_data[0], 64'hDEAD_BEEF_CAFE_F00D);
    check("cont_rid", 64'(rd_id[0]), 64'hA);

    // Reset during R_WAIT abandons the read.
    araddr = 32'h8000_0100; arlen = 8'd0; arid = 4'h1; arvalid = 1'b1;
    tick;
    arvalid = 1'b0;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("abandon_rvalid", 64'(rvalid), 64'd0);
      tick;
    end
    check("abandon_arready", 64'(arready), 64'd1);

    // Address below the decoded window.
    do_ar(32'h0000_1000, 8'd0, 2'b01, 4'hB, lat);
    read_beats(1);
`ifdef YSYX_AXI_SLV_DECERR_EN
    check("oor_rresp", 64'(rd_resp[0]), 64'd3);
    check("oor_rdata", rd_data[0], 64'd0);
`else
    check("oor_rresp", 64'(rd_resp[0]), 64'd0);
`endif
    check("oor_rid", 64'(rd_id[0]), 64'hB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
